// File: rtl/bresenham_line_engine.sv
// Bresenham line rasteriser: latches an endpoint pair on draw_en and streams one pixel per
// valid/ready handshake. Define BLA_PIXEL_COUNT_EN to add the pixel_count output.
module bresenham_line_engine #(
  parameter int COORD_W = 8
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               draw_en,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic               pixel_ready,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               pixel_valid,
  output logic               draw_done,
`ifdef BLA_PIXEL_COUNT_EN
  output logic [COORD_W:0]   pixel_count,
`endif
  output logic               busy
);

  localparam int EW = COORD_W + 3;

  typedef enum logic [1:0] {IDLE, PLOT, DONE, REARM} state_t;

  state_t                    state_q, state_d;
  logic [COORD_W-1:0]        x_q, x_d, y_q, y_d, xe_q, xe_d, ye_q, ye_d;
  logic [COORD_W:0]          dx_q, dx_d;
  logic signed [EW-1:0]      dy_q, dy_d, err_q, err_d;
  logic                      sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic [COORD_W:0]          cnt_q, cnt_d;

  logic [COORD_W-1:0]        adx, ady;
  logic signed [EW-1:0]      dx_e;
  logic signed [EW:0]        e2, dx_ext, dy_ext;
  logic                      step_x, step_y, at_end, load, step;

  assign adx    = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
  assign ady    = (y1 >= y0) ? (y1 - y0) : (y0 - y1);
  assign dx_e   = {2'b00, dx_q};
  assign e2     = {err_q, 1'b0};
  assign dx_ext = {3'b000, dx_q};
  assign dy_ext = {dy_q[EW-1], dy_q};
  // Both step decisions are taken against the pre-update error term.
  assign step_x = (e2 >= dy_ext);
  assign step_y = (e2 <= dx_ext);
  assign at_end = (x_q == xe_q) && (y_q == ye_q);
  assign load   = (state_q == IDLE) && draw_en;
  assign step   = (state_q == PLOT) && draw_en && pixel_ready && !at_end;

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (draw_en) state_d = PLOT;
      PLOT: begin
        if (!draw_en)                   state_d = IDLE;
        else if (pixel_ready && at_end) state_d = DONE;
      end
      DONE:    state_d = REARM;
      REARM:   if (!draw_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    pixel_valid = (state_q == PLOT);
    draw_done   = (state_q == DONE);
    busy        = (state_q != IDLE);
  end

  assign pixel_x = x_q;
  assign pixel_y = y_q;

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    xe_d     = xe_q;
    ye_d     = ye_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    cnt_d    = cnt_q;
    if (load) begin
      x_d      = x0;
      y_d      = y0;
      xe_d     = x1;
      ye_d     = y1;
      dx_d     = {1'b0, adx};
      dy_d     = -$signed({3'b000, ady});
      err_d    = $signed({3'b000, adx}) - $signed({3'b000, ady});
      sx_neg_d = !(x0 < x1);
      sy_neg_d = !(y0 < y1);
      cnt_d    = '0;
    end else begin
      // An accept in the abort cycle still counts, but no step follows it.
      if ((state_q == PLOT) && pixel_ready) cnt_d = cnt_q + (COORD_W+1)'(1);
      if (step) begin
        if (step_x) x_d = sx_neg_q ? (x_q - COORD_W'(1)) : (x_q + COORD_W'(1));
        if (step_y) y_d = sy_neg_q ? (y_q - COORD_W'(1)) : (y_q + COORD_W'(1));
        err_d = err_q + (step_x ? dy_q : '0) + (step_y ? dx_e : '0);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      x_q      <= '0;
      y_q      <= '0;
      xe_q     <= '0;
      ye_q     <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      xe_q     <= xe_d;
      ye_q     <= ye_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef BLA_PIXEL_COUNT_EN
  assign pixel_count = cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt = ^cnt_q;
`endif

endmodule

// File: tb/tb_bresenham_line_engine.sv
// Directed bench for bresenham_line_engine: hand-computed pixel sequences, stall,
// rearm, abort and mid-line reset.
module tb_bresenham_line_engine;
  localparam int COORD_W = 8;

  logic               clk = 1'b0;
  logic               n_rst;
  logic               draw_en;
  logic [COORD_W-1:0] x0, y0, x1, y1;
  logic               pixel_ready;
  logic [COORD_W-1:0] pixel_x, pixel_y;
  logic               pixel_valid, draw_done, busy;
`ifdef BLA_PIXEL_COUNT_EN
  logic [COORD_W:0]   pixel_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  bresenham_line_engine #(.COORD_W(COORD_W)) dut (
    .clk(clk), .n_rst(n_rst), .draw_en(draw_en),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .pixel_ready(pixel_ready),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_valid(pixel_valid), .draw_done(draw_done),
`ifdef BLA_PIXEL_COUNT_EN
    .pixel_count(pixel_count),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_count(input string tag, input int expv);
`ifdef BLA_PIXEL_COUNT_EN
    chk(tag, 32'(pixel_count), 32'(expv));
`else
    if (expv < 0) $display("unreachable %s", tag);
`endif
  endtask

  function automatic void push(input int px, input int py);
    exp_q.push_back({8'(px), 8'(py)});
  endfunction

  // Draws one line with pixel_ready held high, checking every pixel, the done pulse and rearm.
  task automatic draw_line(input string name, input int ax0, input int ay0, input int ax1, input int ay1);
    int n;
    n = exp_q.size();
    x0 = 8'(ax0); y0 = 8'(ay0); x1 = 8'(ax1); y1 = 8'(ay1);
    pixel_ready = 1'b1;
    draw_en = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      chk({name, " valid"}, 32'(pixel_valid), 32'd1);
      chk({name, " pix"}, {16'd0, pixel_x, pixel_y}, {16'd0, exp_q[i]});
      chk({name, " early_done"}, 32'(draw_done), 32'd0);
      tick();
    end
    chk({name, " done"}, 32'(draw_done), 32'd1);
    chk({name, " valid_in_done"}, 32'(pixel_valid), 32'd0);
    chk_count({name, " count"}, n);
    tick();
    chk({name, " done_pulse"}, 32'(draw_done), 32'd0);
    chk({name, " rearm_busy"}, 32'(busy), 32'd1);
    draw_en = 1'b0;
    tick();
    chk({name, " idle"}, 32'(busy), 32'd0);
    chk_count({name, " count_hold"}, n);
    $display("line %s (%0d,%0d)->(%0d,%0d) pixels=%0d", name, ax0, ay0, ax1, ay1, n);
    exp_q.delete();
  endtask

  initial begin
    n_rst = 1'b0; draw_en = 1'b0; pixel_ready = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    tick(); tick();
    chk("rst valid", 32'(pixel_valid), 32'd0);
    chk("rst done", 32'(draw_done), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst pix", {16'd0, pixel_x, pixel_y}, 32'd0);
    chk_count("rst count", 0);
    n_rst = 1'b1;
    tick();
    chk("idle busy", 32'(busy), 32'd0);

    push(0,0); push(1,0); push(2,0); push(3,0);
    draw_line("horiz", 0, 0, 3, 0);

    push(2,5); push(2,4); push(1,3); push(1,2); push(0,1); push(0,0);
    draw_line("steep_neg", 2, 5, 0, 0);

    push(7,7);
    draw_line("zero_len", 7, 7, 7, 7);

    push(0,0); push(1,1); push(2,2); push(3,3);
    draw_line("diag", 0, 0, 3, 3);

    // Stall on (1,0) for three cycles.
    x0 = 8'd0; y0 = 8'd0; x1 = 8'd3; y1 = 8'd0;
    pixel_ready = 1'b1; draw_en = 1'b1;
    tick();
    chk("stall p0", {16'd0, pixel_x, pixel_y}, {16'd0, 8'd0, 8'd0});
    tick();
    pixel_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall hold valid", 32'(pixel_valid), 32'd1);
      chk("stall hold pix", {16'd0, pixel_x, pixel_y}, {16'd0, 8'd1, 8'd0});
      x0 = 8'd9; y1 = 8'd9;  // inputs sampled once; these must be ignored
      tick();
    end
    pixel_ready = 1'b1;
    chk("stall p1 last", {16'd0, pixel_x, pixel_y}, {16'd0, 8'd1, 8'd0});
    tick();
    chk("stall p2", {16'd0, pixel_x, pixel_y}, {16'd0, 8'd2, 8'd0});
    tick();
    chk("stall p3", {16'd0, pixel_x, pixel_y}, {16'd0, 8'd3, 8'd0});
    tick();
    chk("stall done", 32'(draw_done), 32'd1);
    chk_count("stall count", 4);
    $display("line stall (0,0)->(3,0) pixels=4 with 3 stall cycles");

    // draw_en held high after completion must not restart.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rearm no_valid", 32'(pixel_valid), 32'd0);
      chk("rearm no_done", 32'(draw_done), 32'd0);
      chk("rearm busy", 32'(busy), 32'd1);
    end
    draw_en = 1'b0;
    tick();
    chk("rearm idle", 32'(busy), 32'd0);
    $display("rearm held 5 cycles, no restart");
    push(4,4); push(5,4);
    draw_line("after_rearm", 4, 4, 5, 4);

    // Abort on the second pixel.
    x0 = 8'd0; y0 = 8'd0; x1 = 8'd9; y1 = 8'd0;
    pixel_ready = 1'b1; draw_en = 1'b1;
    tick();
    tick();
    chk("abort p1", {16'd0, pixel_x, pixel_y}, {16'd0, 8'd1, 8'd0});
    draw_en = 1'b0;
    tick();
    chk("abort valid", 32'(pixel_valid), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(draw_done), 32'd0);
    chk_count("abort count", 2);
    tick();
    chk("abort done2", 32'(draw_done), 32'd0);
    $display("abort (0,0)->(9,0) after 2 pixels");

    // Reset mid-line.
    x0 = 8'd0; y0 = 8'd0; x1 = 8'd5; y1 = 8'd5;
    draw_en = 1'b1;
    tick();
    tick();
    chk("rst_mid pre", {16'd0, pixel_x, pixel_y}, {16'd0, 8'd1, 8'd1});
    #2;
    n_rst = 1'b0;
    draw_en = 1'b0;
    #1;
    chk("rst_mid valid", 32'(pixel_valid), 32'd0);
    chk("rst_mid busy", 32'(busy), 32'd0);
    chk("rst_mid pix", {16'd0, pixel_x, pixel_y}, 32'd0);
    chk_count("rst_mid count", 0);
    tick();
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_mid no_done", 32'(draw_done), 32'd0);
      chk("rst_mid idle", 32'(busy), 32'd0);
    end
    $display("reset mid-line (0,0)->(5,5)");
    push(0,0); push(1,1); push(2,2); push(3,3);
    draw_line("post_reset", 0, 0, 3, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
